// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared combinational 32-bit adder.
// Holds one registered result at a time and counts the results that are consumed.
module adder_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_src1_i,
  input  logic [DATA_W-1:0] req0_src2_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_src1_i,
  input  logic [DATA_W-1:0] req1_src2_i,
  output logic              req1_ready_o,
  output logic [DATA_W-1:0] add_src1_o,
  output logic [DATA_W-1:0] add_src2_o,
  input  logic [DATA_W-1:0] add_sum_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_sum_o,
  output logic              res_id_o,
  output logic [15:0]       ops_cnt_o
);

  localparam logic PrioInit = PRIO_INIT[0];

  typedef enum logic {StEmpty, StFull} state_e;

  state_e state_q;
  logic   last_grant_q;
  logic   grant;
  logic   can_accept;
  logic   accept;
  logic   consume;

  // Tie goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant = ~last_grant_q;
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    add_src1_o = '0;
    add_src2_o = '0;
    if (req0_valid_i || req1_valid_i) begin
      add_src1_o = grant ? req1_src1_i : req0_src1_i;
      add_src2_o = grant ? req1_src2_i : req0_src2_i;
    end
  end

  // Gating with rst_i keeps both readies low for the whole reset window.
  assign can_accept   = rst_i & ((state_q == StEmpty) | res_ready_i);
  assign req0_ready_o = can_accept & ~grant & req0_valid_i;
  assign req1_ready_o = can_accept &  grant & req1_valid_i;
  assign accept       = req0_ready_o | req1_ready_o;
  assign consume      = (state_q == StFull) & res_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StEmpty;
      res_valid_o  <= 1'b0;
      res_sum_o    <= '0;
      res_id_o     <= 1'b0;
      ops_cnt_o    <= '0;
      last_grant_q <= ~PrioInit;
    end else begin
      if (consume) begin
        ops_cnt_o <= ops_cnt_o + 16'd1;
      end
      if (accept) begin
        state_q      <= StFull;
        res_valid_o  <= 1'b1;
        res_sum_o    <= add_sum_i;
        res_id_o     <= grant;
        last_grant_q <= grant;
      end else if (consume) begin
        state_q     <= StEmpty;
        res_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of the held result, priority and counter.
module tb_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0v, r1v;
  logic [31:0] r0s1, r0s2, r1s1, r1s2;
  logic        r0rdy, r1rdy;
  logic [31:0] add_s1, add_s2, add_sum;
  logic        res_valid, res_ready, res_id;
  logic [31:0] res_sum;
  logic [15:0] ops_cnt;

  int errors = 0;
  int checks = 0;

  // Model state
  logic        m_held;
  logic [31:0] m_sum;
  logic        m_id;
  logic        m_lg;
  logic [15:0] m_cnt;

  adder_arbiter #(.DATA_W(32), .PRIO_INIT(0)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .req0_valid_i(r0v),
    .req0_src1_i (r0s1),
    .req0_src2_i (r0s2),
    .req0_ready_o(r0rdy),
    .req1_valid_i(r1v),
    .req1_src1_i (r1s1),
    .req1_src2_i (r1s2),
    .req1_ready_o(r1rdy),
    .add_src1_o  (add_s1),
    .add_src2_o  (add_s2),
    .add_sum_i   (add_sum),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum_o   (res_sum),
    .res_id_o    (res_id),
    .ops_cnt_o   (ops_cnt)
  );

  // The shared adder itself.
  assign add_sum = add_s1 + add_s2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_grant();
    if (r0v && r1v) return ~m_lg;
    return r1v;
  endfunction

  task automatic m_reset();
    m_held = 1'b0;
    m_sum  = '0;
    m_id   = 1'b0;
    m_cnt  = '0;
    m_lg   = 1'b1;
  endtask

  // Called 1 time unit after a rising edge with inputs already set.
  task automatic cycle();
    logic        g, can, e0, e1, any;
    logic [31:0] es1, es2;
    g   = m_grant();
    can = !m_held || res_ready;
    any = r0v || r1v;
    e0  = rst_n && can && r0v && !g;
    e1  = rst_n && can && r1v && g;
    es1 = any ? (g ? r1s1 : r0s1) : 32'h0;
    es2 = any ? (g ? r1s2 : r0s2) : 32'h0;
    #3;
    chk("req0_ready", {31'b0, r0rdy}, {31'b0, e0});
    chk("req1_ready", {31'b0, r1rdy}, {31'b0, e1});
    chk("add_src1", add_s1, es1);
    chk("add_src2", add_s2, es2);
    chk("res_valid", {31'b0, res_valid}, {31'b0, m_held});
    chk("res_sum", res_sum, m_sum);
    chk("res_id", {31'b0, res_id}, {31'b0, m_id});
    chk("ops_cnt", {16'b0, ops_cnt}, {16'b0, m_cnt});
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      if (m_held && res_ready) m_cnt = m_cnt + 16'd1;
      if (e0 || e1) begin
        m_held = 1'b1;
        m_sum  = es1 + es2;
        m_id   = g;
        m_lg   = g;
      end else if (m_held && res_ready) begin
        m_held = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    r0v = 0; r1v = 0; res_ready = 0;
    r0s1 = 0; r0s2 = 0; r1s1 = 0; r1s2 = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    cycle();
    chk("rst_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_sum", res_sum, 32'd0);
    chk("rst_cnt", {16'b0, ops_cnt}, 32'd0);
    rst_n = 1'b1;

    // Single op 5+7
    r0v = 1; r0s1 = 5; r0s2 = 7; res_ready = 1;
    cycle();
    r0v = 0;
    chk("single_valid", {31'b0, res_valid}, 32'd1);
    chk("single_sum", res_sum, 32'd12);
    chk("single_id", {31'b0, res_id}, 32'd0);
    cycle();
    chk("single_cnt", {16'b0, ops_cnt}, 32'd1);

    // Tie after reset alternates starting at requester 0
    do_reset();
    r0v = 1; r1v = 1; res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      r0s1 = $urandom; r0s2 = $urandom; r1s1 = $urandom; r1s2 = $urandom;
      cycle();
      chk("tie_id", {31'b0, res_id}, {31'b0, 1'(i % 2)});
    end

    // Backpressure with a wrapping sum, then same-edge consume and accept
    idle_inputs();
    cycle();
    r0v = 1; r0s1 = 32'hFFFF_FFFF; r0s2 = 1; res_ready = 1;
    cycle();
    r0v = 0; res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      r0v = 1'(i % 2);
      r1v = 1'(i / 2);
      cycle();
      chk("bp_sum", res_sum, 32'd0);
      chk("bp_valid", {31'b0, res_valid}, 32'd1);
    end
    r0v = 0; r1v = 1; r1s1 = 3; r1s2 = 4; res_ready = 1;
    cycle();
    chk("bp_acc_valid", {31'b0, res_valid}, 32'd1);
    chk("bp_acc_sum", res_sum, 32'd7);
    chk("bp_acc_id", {31'b0, res_id}, 32'd1);
    r1v = 0;

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      r0v = 1'($urandom_range(0, 1));
      r1v = 1'($urandom_range(0, 1));
      r0s1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      r0s2 = $urandom;
      r1s1 = $urandom;
      r1s2 = ($urandom_range(0, 7) == 0) ? 32'h1 : $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 39) != 0);
      cycle();
    end
    rst_n = 1'b1;

    // Reset while holding a result
    idle_inputs();
    r0v = 1; r0s1 = 9; r0s2 = 9;
    cycle();
    r0v = 0;
    chk("mid_full", {31'b0, res_valid}, 32'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_valid", {31'b0, res_valid}, 32'd0);
    chk("mid_sum", res_sum, 32'd0);
    chk("mid_cnt", {16'b0, ops_cnt}, 32'd0);
    r0v = 1; r1v = 1; res_ready = 1;
    cycle();
    chk("mid_tie_id", {31'b0, res_id}, 32'd0);

    // Counter wrap
    do_reset();
    r0v = 1; r1v = 1; res_ready = 1;
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
      r0s1 = i; r1s1 = ~i;
      cycle();
    end
    chk("wrap_ffff", {16'b0, ops_cnt}, 32'h0000_FFFF);
    cycle();
    chk("wrap_zero", {16'b0, ops_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/sum width; the shared Adder is 32-bit, so only 32 is supported.
REQ-002 Parameter: PRIO_INIT, 0, requester that wins the first tie after reset.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 req0_valid_i  input  1  requester 0 has an add pending.
REQ-006 req0_src1_i / req0_src2_i  input  32 each  requester 0 operands.
REQ-007 req0_ready_o  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid_i, req1_src1_i, req1_src2_i, req1_ready_o  same as REQ-005..007, for requester 1.
REQ-009 add_src1_o / add_src2_o  output  32 each  operands driven to the shared combinational Adder.
REQ-010 add_sum_i  input  32  sum_o returned by the shared Adder, same cycle.
REQ-011 res_valid_o  output  1  registered result available.
REQ-012 res_ready_i  input  1  consumer takes the result this cycle.
REQ-013 res_sum_o  output  32  registered sum.
REQ-014 res_id_o  output  1  requester that owns res_sum_o.
REQ-015 ops_cnt_o  output  16  count of results consumed.

Function
REQ-016 The block has two states: EMPTY (no result held) and FULL (result held, res_valid_o=1).
REQ-017 can_accept = EMPTY, or FULL with res_ready_i=1, so back-to-back throughput is one op per cycle.
REQ-018 Arbitration: one valid requester gets the grant; if both are valid, the requester not in last_grant gets it (round-robin).
REQ-019 reqN_ready_o = can_accept and grant==N; at most one ready is high per cycle.
REQ-020 Ready may depend on either valid input.
REQ-021 Requesters keep valid and operands stable until ready is seen; the block does not check this.
REQ-022 add_src1_o/add_src2_o carry the granted requester's operands whenever any valid is high, else 32'h0; this path is combinational.
REQ-023 Accept occurs on a clock edge where reqN_valid_i=1 and reqN_ready_o=1. On accept:
- res_sum_o <= add_sum_i
- res_id_o <= N
- res_valid_o <= 1
- last_grant <= N
- next state is FULL.
REQ-024 Latency: res_valid_o rises exactly 1 cycle after the accept edge.
REQ-025 The result is consumed on an edge where res_valid_o=1 and res_ready_i=1; ops_cnt_o increments by 1 on each such edge.
REQ-026 When the result is consumed and there is no simultaneous accept: next state is EMPTY, res_valid_o <= 0, res_sum_o/res_id_o hold their values.
REQ-027 When the result is consumed and an accept occurs on the same edge: the new result replaces the old one and state stays FULL.
REQ-028 In FULL with res_ready_i=0: res_sum_o and res_id_o hold stable, and both readies are 0.
REQ-029 last_grant changes only on accept; a requester that deasserts valid without being accepted does not change priority.
REQ-030 Arithmetic is modulo 2^32; carry-out is discarded (e.g. 32'hFFFFFFFF + 1 = 0).
REQ-031 ops_cnt_o wraps from 16'hFFFF to 16'h0000.

Reset
REQ-032 When rst_i=0 at a rising edge:
- state = EMPTY, res_valid_o = 0, res_sum_o = 0, res_id_o = 0, ops_cnt_o = 0
- last_grant = ~PRIO_INIT.
REQ-033 While rst_i=0, req0_ready_o=req1_ready_o=0.
REQ-034 Reset asserted while FULL discards the held result without counting it.
REQ-035 After rst_i returns high, the first accept can occur on the next edge.

Verification
REQ-036 Single op: req0 valid, 5+7, res_ready_i=1 -> req0_ready_o=1; next cycle res_valid_o=1, res_sum_o=12, res_id_o=0; one edge later ops_cnt_o=1.
REQ-037 Tie after reset (PRIO_INIT=0): both valid every cycle, res_ready_i=1 -> grant sequence 0,1,0,1; results appear one per cycle with res_id_o alternating.
REQ-038 Backpressure: result 32'hFFFFFFFF+1 held with res_ready_i=0 for 3 cycles -> res_sum_o=0 stable; both readies 0; ops_cnt_o unchanged. Then res_ready_i=1 with req1 valid -> same-edge consume and accept, state stays FULL.
REQ-039 Reset mid-op: rst_i=0 while FULL -> next edge res_valid_o=0, res_sum_o=0, ops_cnt_o=0. First tie after release goes to PRIO_INIT.
REQ-040 Counter wrap: preload via 65535 consumed results -> ops_cnt_o=16'hFFFF; one more consume -> 16'h0000.
